wb_cmd_master: RTL and testbench
================================

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, Wishbone address width.
REQ-002 SHALL have parameter DATA_W, default 8, Wishbone data width.
REQ-003 SHALL have parameter DEPTH, default 4, command FIFO entries; power of two, at least 2.
REQ-004 SHALL have parameter TIMEOUT, default 16, cycles to wait for ack before error; at least 1.
REQ-005 SHALL use one clock and a synchronous, active-high reset: wb_clk_i  in  1  clock, all logic on rising edge; wb_rst_i  in  1  synchronous active-high reset.
REQ-006 cmd_valid_i  in  1  command present.
REQ-007 cmd_ready_o  out  1  command FIFO can accept.
REQ-008 cmd_we_i  in  1  1=write, 0=read.
REQ-009 cmd_addr_i  in  ADDR_W  target address.
REQ-010 cmd_wdata_i  in  DATA_W  write data.
REQ-011 rsp_valid_o  out  1  response held.
REQ-012 rsp_ready_i  in  1  response consumed.
REQ-013 rsp_rdata_o  out  DATA_W  read data; 0 for writes and errors.
REQ-014 rsp_err_o  out  1  access timed out.
REQ-015 wb_adr_o  out  ADDR_W; wb_dat_o  out  DATA_W; wb_we_o  out  1; wb_stb_o  out  1; wb_cyc_o  out  1: Wishbone classic master outputs.
REQ-016 wb_dat_i  in  DATA_W; wb_ack_i  in  1; wb_inta_i  in  1: slave data, acknowledge and interrupt.
REQ-017 irq_o  out  1  sticky interrupt flag; irq_clr_i  in  1  clears irq_o.
REQ-018 busy_o  out  1  high when FSM not IDLE or FIFO non-empty.

Function
REQ-019 cmd_ready_o SHALL equal FIFO-not-full; a command SHALL be pushed on an edge where cmd_valid_i and cmd_ready_o are both high.
REQ-020 The FIFO SHALL be first-in first-out with wrapping pointers and a full count of DEPTH; when full, cmd_valid_i SHALL be ignored.
REQ-021 Push and pop on the same edge SHALL both take effect.
REQ-022 The FSM SHALL have states IDLE, BUS and HOLD.
REQ-023 IDLE to BUS SHALL occur when the FIFO is non-empty and rsp_valid_o is 0: pop the head, register adr/dat/we, and assert wb_cyc_o and wb_stb_o from the next cycle.
REQ-024 Latency: a command pushed at edge E0 into an empty, idle block SHALL show wb_cyc_o/wb_stb_o high after edge E0+2.
REQ-025 In BUS, wb_adr_o, wb_dat_o and wb_we_o SHALL remain stable while wb_cyc_o is high.
REQ-026 In BUS, wb_ack_i sampled high at edge Ek SHALL drop cyc/stb after Ek, set rsp_valid_o=1 and rsp_err_o=0, and move to HOLD.
REQ-027 On such an ack, rsp_rdata_o SHALL be wb_dat_i sampled at Ek for reads and 0 for writes.
REQ-028 The timeout counter SHALL reset on BUS entry; if TIMEOUT edges in BUS pass without ack, cyc/stb SHALL drop, rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0, and the FSM SHALL go to HOLD.
REQ-029 An ack on the same edge as timeout expiry SHALL win, giving no error.
REQ-030 In HOLD, rsp_* SHALL stay stable until rsp_valid_o and rsp_ready_i are both high at an edge; rsp_valid_o SHALL then clear and the FSM SHALL go to IDLE.
REQ-031 Only one transaction SHALL be outstanding; no back-to-back cycles without passing through IDLE.
REQ-032 irq_o SHALL set on a registered rising edge of wb_inta_i and clear on irq_clr_i; if both occur on the same edge, set wins.

Reset
REQ-033 While wb_rst_i is high at an edge, the block SHALL empty the FIFO, set the FSM to IDLE and the timeout counter to 0, and drive wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid_o, rsp_err_o, irq_o and busy_o to 0; wb_adr_o, wb_dat_o and rsp_rdata_o to 0; and cmd_ready_o to 1 after reset.
REQ-034 Reset mid-transaction SHALL drop wb_cyc_o and wb_stb_o on that edge, discard the FIFO contents, and produce no response.

Verification
REQ-035 Write 0x02 <- 0xA5, slave acks after 3 cycles: wb_cyc_o high for 3 cycles with adr 2, dat 0xA5, we 1; one response with rdata 0, err 0.
REQ-036 Read 0x04, slave acks with 0x3C: rsp_rdata_o=0x3C; rsp_valid_o held with rsp_ready_i low for 5 cycles, data stable throughout.
REQ-037 Push 5 commands with DEPTH=4 and no draining: cmd_ready_o low after 4th; issue order matches push order; last accepted command executes after the FIFO drains.
REQ-038 Read with no ack: after 16 cycles cyc/stb drop, rsp_err_o=1, rdata 0; ack arriving exactly on cycle 16 gives err 0.
REQ-039 wb_rst_i asserted during BUS with 3 queued commands: cyc/stb low next cycle, busy_o 0, no response, FIFO empty.
REQ-040 Pulse wb_inta_i: irq_o sets; irq_clr_i coincident with a new rising edge leaves irq_o 1.

Source files
------------

// File: rtl/wb_cmd_master.sv
// Queued Wishbone classic master: commands enter a FIFO, run one at a time, and return one response each.
// Latency: cyc/stb rise two edges after a push into an idle block; full FIFO deasserts cmd_ready_o, held response blocks issue.
module wb_cmd_master #(
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_we_o,
  output logic              wb_stb_o,
  output logic              wb_cyc_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_inta_i,
  output logic              irq_o,
  input  logic              irq_clr_i,
  output logic              busy_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  cmd_t            mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic [1:0]      state;
  logic [TW-1:0]   tcnt;
  logic            inta_q;
  logic            push;
  logic            pop;
  cmd_t            head;

  assign cmd_ready_o = (count != FULL);
  assign push        = cmd_valid_i && cmd_ready_o;
  assign pop         = (state == IDLE) && (count != '0) && !rsp_valid_o;
  assign head        = mem[rptr];
  assign busy_o      = (state != IDLE) || (count != '0);

  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem[wptr] <= '{we: cmd_we_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      tcnt        <= '0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            wb_adr_o <= head.addr;
            wb_dat_o <= head.wdata;
            wb_we_o  <= head.we;
            tcnt     <= '0;
            state    <= BUS;
          end
        end
        BUS: begin
          // First BUS cycle only launches the strobe; the timeout counts edges with cyc high.
          if (!wb_cyc_o) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
          end else if (wb_ack_i) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= wb_we_o ? '0 : wb_dat_i;
            state       <= HOLD;
          end else if (tcnt == TLAST) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            rsp_rdata_o <= '0;
            state       <= HOLD;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        HOLD: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A fresh interrupt edge takes priority over a coincident clear.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      inta_q <= 1'b0;
      irq_o  <= 1'b0;
    end else begin
      inta_q <= wb_inta_i;
      if (wb_inta_i && !inta_q) irq_o <= 1'b1;
      else if (irq_clr_i)       irq_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed scenarios plus randomized traffic against a queue-based model.
module tb_wb_cmd_master;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_we_i;
  logic [AW-1:0] cmd_addr_i;
  logic [DW-1:0] cmd_wdata_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic          wb_we_o;
  logic          wb_stb_o;
  logic          wb_cyc_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i;
  logic          wb_inta_i;
  logic          irq_o;
  logic          irq_clr_i;
  logic          busy_o;

  int vectors = 0;
  int errors  = 0;

  wb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_inta_i(wb_inta_i),
    .irq_o(irq_o), .irq_clr_i(irq_clr_i), .busy_o(busy_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  function automatic cmd_t rand_cmd();
    logic [31:0] r;
    cmd_t c;
    r = $urandom;
    c.we = r[31];
    c.addr = r[AW-1:0];
    c.data = r[AW+DW-1:AW];
    return c;
  endfunction

  task automatic push(input cmd_t c);
    cmd_valid_i = 1'b1;
    cmd_we_i = c.we;
    cmd_addr_i = c.addr;
    cmd_wdata_i = c.data;
    step();
    cmd_valid_i = 1'b0;
  endtask

  task automatic release_rsp();
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
  endtask

  // Slave side: waits for cyc, acks on the ack_on-th cycle with cyc high (0 = never), reports what it saw.
  task automatic serve(input int ack_on, input logic [DW-1:0] data, output int ncyc,
                       output cmd_t seen, output logic stable, output logic started);
    int guard;
    logic [31:0] r;
    ncyc = 0; stable = 1'b1; started = 1'b0; seen = '0;
    guard = 0;
    while (!wb_cyc_o && guard < 40) begin step(); guard++; end
    if (!wb_cyc_o) return;
    started = 1'b1;
    seen = '{we: wb_we_o, addr: wb_adr_o, data: wb_dat_o};
    guard = 0;
    while (wb_cyc_o && guard < 100) begin
      ncyc++;
      if (wb_adr_o !== seen.addr || wb_dat_o !== seen.data || wb_we_o !== seen.we || wb_stb_o !== 1'b1)
        stable = 1'b0;
      r = $urandom;
      if (ncyc == ack_on) begin wb_ack_i = 1'b1; wb_dat_i = data; end
      else begin wb_ack_i = 1'b0; wb_dat_i = r[DW-1:0]; end
      step();
      guard++;
    end
    wb_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    step(); step();
    wb_rst_i = 1'b0;
    vectors++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready_o); end
    vectors++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin errors++; $display("FAIL reset_bus_ctrl: got %b want 000", {wb_cyc_o, wb_stb_o, wb_we_o}); end
    vectors++; if ({rsp_valid_o, rsp_err_o, irq_o, busy_o} !== 4'b0000) begin errors++; $display("FAIL reset_status: got %b want 0000", {rsp_valid_o, rsp_err_o, irq_o, busy_o}); end
    vectors++; if (wb_adr_o !== '0 || wb_dat_o !== '0 || rsp_rdata_o !== '0) begin errors++; $display("FAIL reset_data: got adr %h dat %h rdata %h want 0", wb_adr_o, wb_dat_o, rsp_rdata_o); end
  endtask

  task automatic test_write();
    cmd_t c, seen;
    int ncyc;
    logic stable, started;
    c = '{we: 1'b1, addr: 3'd2, data: 8'hA5};
    push(c);
    vectors++; if (wb_cyc_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL write_lat_e0: got cyc %b busy %b want 0 1", wb_cyc_o, busy_o); end
    step();
    vectors++; if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL write_lat_e1: got cyc %b want 0", wb_cyc_o); end
    step();
    vectors++; if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1) begin errors++; $display("FAIL write_lat_e2: got cyc %b stb %b want 1 1", wb_cyc_o, wb_stb_o); end
    serve(3, 8'hFF, ncyc, seen, stable, started);
    vectors++; if (seen !== c || !started) begin errors++; $display("FAIL write_bus_fields: got %h want %h", seen, c); end
    vectors++; if (ncyc != 3 || !stable) begin errors++; $display("FAIL write_cyc_len: got %0d stable %b want 3 1", ncyc, stable); end
    vectors++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 8'h00) begin errors++; $display("FAIL write_rsp: got v%b e%b d%h want v1 e0 d00", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
    release_rsp();
    vectors++; if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL write_rsp_clear: got v%b busy %b want 0 0", rsp_valid_o, busy_o); end
  endtask

  task automatic test_read_hold();
    cmd_t c, seen;
    int ncyc;
    logic stable, started;
    logic [31:0] r;
    c = '{we: 1'b0, addr: 3'd4, data: 8'h77};
    push(c);
    serve(2, 8'h3C, ncyc, seen, stable, started);
    vectors++; if (seen !== c || !started || ncyc != 2) begin errors++; $display("FAIL read_bus: got %h n%0d want %h n2", seen, ncyc, c); end
    vectors++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 8'h3C) begin errors++; $display("FAIL read_rsp: got v%b e%b d%h want v1 e0 d3c", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
    for (int k = 0; k < 5; k++) begin
      r = $urandom;
      wb_dat_i = r[DW-1:0];
      step();
      vectors++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 8'h3C || rsp_err_o !== 1'b0) begin errors++; $display("FAIL read_hold_%0d: got v%b d%h want v1 d3c", k, rsp_valid_o, rsp_rdata_o); end
    end
    release_rsp();
    vectors++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL read_rsp_clear: got %b want 0", rsp_valid_o); end
  endtask

  task automatic test_fifo_full();
    cmd_t blk, c, seen;
    cmd_t cs[5];
    cmd_t q[$];
    int ncyc;
    logic stable, started, exp_rdy, cyc_seen;
    logic [31:0] r;
    blk = rand_cmd();
    push(blk);
    serve(1, 8'h11, ncyc, seen, stable, started);
    vectors++; if (!started || rsp_valid_o !== 1'b1) begin errors++; $display("FAIL full_blocker: got started %b v%b want 1 1", started, rsp_valid_o); end
    for (int j = 0; j < 5; j++) begin
      cs[j] = rand_cmd();
      cmd_valid_i = 1'b1; cmd_we_i = cs[j].we; cmd_addr_i = cs[j].addr; cmd_wdata_i = cs[j].data;
      exp_rdy = (q.size() < DEPTH);
      vectors++; if (cmd_ready_o !== exp_rdy) begin errors++; $display("FAIL full_ready_%0d: got %b want %b", j, cmd_ready_o, exp_rdy); end
      step();
      if (exp_rdy) q.push_back(cs[j]);
    end
    cmd_valid_i = 1'b0;
    vectors++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready_low: got %b want 0", cmd_ready_o); end
    release_rsp();
    step();
    vectors++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop: got %b want 1", cmd_ready_o); end
    while (q.size() > 0) begin
      c = q.pop_front();
      r = $urandom;
      serve($urandom_range(1, 5), r[DW-1:0], ncyc, seen, stable, started);
      vectors++; if (seen !== c || !started || !stable) begin errors++; $display("FAIL full_order: got %h started %b want %h", seen, started, c); end
      vectors++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_rdata_o !== (c.we ? 8'h00 : r[DW-1:0])) begin errors++; $display("FAIL full_rsp: got v%b e%b d%h", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
      release_rsp();
    end
    vectors++; if (busy_o !== 1'b0) begin errors++; $display("FAIL full_drained_busy: got %b want 0", busy_o); end
    cyc_seen = 1'b0;
    repeat (6) begin step(); if (wb_cyc_o !== 1'b0) cyc_seen = 1'b1; end
    vectors++; if (cyc_seen !== 1'b0) begin errors++; $display("FAIL full_dropped_cmd: got cyc %b want 0", cyc_seen); end
  endtask

  task automatic test_timeout();
    cmd_t c, seen;
    int ncyc;
    logic stable, started;
    c = rand_cmd(); c.we = 1'b0;
    push(c);
    serve(0, 8'h00, ncyc, seen, stable, started);
    vectors++; if (ncyc != TIMEOUT || !started || !stable) begin errors++; $display("FAIL timeout_len: got %0d want %0d", ncyc, TIMEOUT); end
    vectors++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_rdata_o !== 8'h00 || wb_stb_o !== 1'b0) begin errors++; $display("FAIL timeout_rsp: got v%b e%b d%h stb%b want v1 e1 d00 stb0", rsp_valid_o, rsp_err_o, rsp_rdata_o, wb_stb_o); end
    release_rsp();
    c = rand_cmd(); c.we = 1'b0;
    push(c);
    serve(TIMEOUT, 8'h5A, ncyc, seen, stable, started);
    vectors++; if (ncyc != TIMEOUT || seen !== c) begin errors++; $display("FAIL ack_at_expiry_len: got %0d want %0d", ncyc, TIMEOUT); end
    vectors++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 8'h5A) begin errors++; $display("FAIL ack_at_expiry_rsp: got v%b e%b d%h want v1 e0 d5a", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
    release_rsp();
  endtask

  task automatic test_reset_mid();
    cmd_t c;
    logic bad;
    for (int j = 0; j < 4; j++) begin
      c = rand_cmd();
      cmd_valid_i = 1'b1; cmd_we_i = c.we; cmd_addr_i = c.addr; cmd_wdata_i = c.data;
      step();
    end
    cmd_valid_i = 1'b0;
    vectors++; if (wb_cyc_o !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got cyc %b busy %b want 1 1", wb_cyc_o, busy_o); end
    wb_rst_i = 1'b1;
    step();
    wb_rst_i = 1'b0;
    vectors++; if ({wb_cyc_o, wb_stb_o, busy_o, rsp_valid_o} !== 4'b0000 || cmd_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_post: got cyc%b stb%b busy%b v%b rdy%b want 0 0 0 0 1", wb_cyc_o, wb_stb_o, busy_o, rsp_valid_o, cmd_ready_o); end
    bad = 1'b0;
    repeat (20) begin step(); if (wb_cyc_o !== 1'b0 || rsp_valid_o !== 1'b0 || busy_o !== 1'b0) bad = 1'b1; end
    vectors++; if (bad !== 1'b0) begin errors++; $display("FAIL rstmid_quiet: got activity %b want 0", bad); end
  endtask

  task automatic test_irq();
    logic m, prev;
    logic [31:0] r;
    wb_inta_i = 1'b0; irq_clr_i = 1'b0;
    step(); step();
    wb_inta_i = 1'b1;
    step();
    vectors++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", irq_o); end
    irq_clr_i = 1'b1;
    step();
    vectors++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", irq_o); end
    irq_clr_i = 1'b0; wb_inta_i = 1'b0;
    step();
    wb_inta_i = 1'b1;
    step();
    wb_inta_i = 1'b0;
    step();
    wb_inta_i = 1'b1; irq_clr_i = 1'b1;
    step();
    vectors++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_set_wins: got %b want 1", irq_o); end
    wb_inta_i = 1'b0; irq_clr_i = 1'b1;
    step();
    m = 1'b0; prev = 1'b0;
    vectors++; if (irq_o !== m) begin errors++; $display("FAIL irq_clear2: got %b want 0", irq_o); end
    for (int k = 0; k < 30; k++) begin
      r = $urandom;
      wb_inta_i = r[0];
      irq_clr_i = (r[2:1] == 2'b00);
      if (wb_inta_i && !prev) m = 1'b1;
      else if (irq_clr_i) m = 1'b0;
      prev = wb_inta_i;
      step();
      vectors++; if (irq_o !== m) begin errors++; $display("FAIL irq_rand_%0d: got %b want %b", k, irq_o, m); end
    end
    wb_inta_i = 1'b0; irq_clr_i = 1'b0;
  endtask

  task automatic test_random();
    cmd_t q[$];
    cmd_t c, nxt, seen;
    int ncyc, ack_on, exp_n, h;
    logic stable, started, exp_ok;
    logic [DW-1:0] rd, exp_rd;
    logic [31:0] r;
    c = rand_cmd();
    push(c);
    q.push_back(c);
    for (int i = 0; i < 12; i++) begin
      c = q.pop_front();
      ack_on = $urandom_range(0, 19);
      r = $urandom; rd = r[DW-1:0];
      serve(ack_on, rd, ncyc, seen, stable, started);
      exp_ok = (ack_on >= 1 && ack_on <= TIMEOUT);
      exp_n = exp_ok ? ack_on : TIMEOUT;
      exp_rd = (exp_ok && !c.we) ? rd : '0;
      vectors++; if (!started || seen !== c || !stable) begin errors++; $display("FAIL rand_%0d_bus: got %h started %b stable %b want %h", i, seen, started, stable, c); end
      vectors++; if (ncyc != exp_n) begin errors++; $display("FAIL rand_%0d_len: got %0d want %0d", i, ncyc, exp_n); end
      vectors++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== !exp_ok || rsp_rdata_o !== exp_rd) begin errors++; $display("FAIL rand_%0d_rsp: got v%b e%b d%h want v1 e%b d%h", i, rsp_valid_o, rsp_err_o, rsp_rdata_o, !exp_ok, exp_rd); end
      if (i < 11) begin
        nxt = rand_cmd();
        push(nxt);
        q.push_back(nxt);
      end
      h = $urandom_range(0, 3);
      for (int k = 0; k <= h; k++) begin
        vectors++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== !exp_ok || rsp_rdata_o !== exp_rd || wb_cyc_o !== 1'b0) begin errors++; $display("FAIL rand_%0d_hold: got v%b e%b d%h cyc%b", i, rsp_valid_o, rsp_err_o, rsp_rdata_o, wb_cyc_o); end
        if (k < h) step();
      end
      release_rsp();
      vectors++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rand_%0d_clear: got %b want 0", i, rsp_valid_o); end
    end
  endtask

  initial begin
    wb_rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
    rsp_ready_i = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_inta_i = 1'b0; irq_clr_i = 1'b0;
    test_reset();
    test_write();
    test_read_hold();
    test_fifo_full();
    test_timeout();
    test_reset_mid();
    test_irq();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
